clk_div_prog: RTL and testbench

Programmable integer clock divider and enable-pulse generator.
- Divides `clk` by a run-time divisor N (2 to 2^WIDTH-1).
- Produces `clk_out` at exactly 50% duty for both even and odd N; odd N uses a half-cycle extension taken on the falling edge of `clk`.
- Produces a one-cycle `tick` strobe per output period, for synchronous consumers.
- Replaces fixed-ratio dividers in the access-control timing chain (display scan, debounce, timeout bases).

---
 rtl/clk_div_prog.sv | 101 ++++++++++
 tb/tb_clk_div_prog.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with 50%-duty output for any divisor >= 2.
// A single falling-edge flop adds the half cycle that odd divisors need.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic             err,
    output logic [WIDTH-1:0] div_cur
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pend;
    logic             pend_valid;
    logic             running;
    logic             pos_hi;
    logic             neg_hi;

    logic             load_ok;
    logic             wrap;
    logic             start;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH-1:0] half_next;
    logic [WIDTH-1:0] pend_next;
    logic             pend_valid_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_ok         = load && (div_in >= MIN_DIV);
        wrap            = running && (cnt == div_cur - ONE);
        start           = en && (!running || wrap);
        cnt_next        = '0;
        div_next        = div_cur;
        pend_next       = pend;
        pend_valid_next = pend_valid;

        if (load_ok) begin
            pend_next       = div_in;
            pend_valid_next = 1'b1;
        end

        // A divisor only changes at a period boundary, so the running period
        // always completes with the divisor it started with.
        if (start) begin
            if (load_ok) begin
                div_next        = div_in;
                pend_valid_next = 1'b0;
            end else if (pend_valid) begin
                div_next        = pend;
                pend_valid_next = 1'b0;
            end
        end else if (en) begin
            cnt_next = cnt + ONE;
        end

        half_next = div_next >> 1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            running    <= 1'b0;
            pend       <= '0;
            pend_valid <= 1'b0;
            div_cur    <= DEF_DIV;
            pos_hi     <= 1'b0;
            tick       <= 1'b0;
            err        <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            running    <= en;
            pend       <= pend_next;
            pend_valid <= pend_valid_next;
            div_cur    <= div_next;
            pos_hi     <= en && (cnt_next < half_next);
            tick       <= start;
            err        <= load && !load_ok;
        end
    end

    // Half-cycle delayed copy of pos_hi; only odd divisors use it.
    always_ff @(negedge clk) begin
        if (reset) neg_hi <= 1'b0;
        else       neg_hi <= pos_hi;
    end

    assign clk_out = pos_hi | (div_cur[0] & neg_hi);

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: per-cycle expectations queued as stimulus is
// driven, then popped and compared after the rising and the falling edge.
module tb_clk_div_prog;

    typedef struct packed {
        logic       tick;
        logic       co_rise;  // clk_out in the first half of the cycle
        logic       co_fall;  // clk_out in the second half of the cycle
        logic       err;
        logic [7:0] div;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] div_in;
    logic       clk_out;
    logic       tick;
    logic       err;
    logic [7:0] div_cur;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .clk_out (clk_out),
        .tick    (tick),
        .err     (err),
        .div_cur (div_cur)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after both edges.
    task automatic cyc(input logic r, input logic e, input logic l, input logic [7:0] d,
                       input exp_t x);
        exp_t got;
        reset  = r;
        en     = e;
        load   = l;
        div_in = d;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("tick", {7'd0, tick}, {7'd0, got.tick});
        check("clk_out_rise_half", {7'd0, clk_out}, {7'd0, got.co_rise});
        check("err", {7'd0, err}, {7'd0, got.err});
        check("div_cur", div_cur, got.div);
        @(negedge clk);
        #1;
        check("clk_out_fall_half", {7'd0, clk_out}, {7'd0, got.co_fall});
    endtask

    // Cycle k of an n-cycle period: high for the first n of its 2n half-cycles.
    task automatic pcyc(input int n, input int k, input logic l = 1'b0,
                        input logic [7:0] d = 8'd0, input logic e_err = 1'b0);
        exp_t x;
        x.tick    = (k == 0);
        x.co_rise = (2 * k < n);
        x.co_fall = (2 * k + 1 < n);
        x.err     = e_err;
        x.div     = 8'(n);
        cyc(1'b0, 1'b1, l, d, x);
    endtask

    task automatic period(input int n);
        for (int k = 0; k < n; k++) pcyc(n, k);
    endtask

    task automatic idle(input logic r, input logic rise, input logic [7:0] dv);
        exp_t x;
        x = '{tick: 1'b0, co_rise: rise, co_fall: 1'b0, err: 1'b0, div: dv};
        cyc(r, 1'b0, 1'b0, 8'd0, x);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; div_in = 8'd0;
        @(posedge clk);
        @(negedge clk);
        #1;
        // Reset state
        idle(1'b1, 1'b0, 8'd5);
        idle(1'b0, 1'b0, 8'd5);

        // Default N=5
        repeat (3) period(5);

        // Rejected loads: err pulses, divisor unchanged
        pcyc(5, 0); pcyc(5, 1, 1'b1, 8'd1, 1'b1); pcyc(5, 2, 1'b1, 8'd0, 1'b1);
        pcyc(5, 3); pcyc(5, 4);

        // Load 4 mid-period; later invalid load leaves the pending 4 intact
        pcyc(5, 0); pcyc(5, 1, 1'b1, 8'd4); pcyc(5, 2);
        pcyc(5, 3, 1'b1, 8'd0, 1'b1); pcyc(5, 4);
        period(4);

        // Pending 3 overridden by a load of 2 on the wrap edge
        pcyc(4, 0); pcyc(4, 1, 1'b1, 8'd6); pcyc(4, 2, 1'b1, 8'd3); pcyc(4, 3);
        pcyc(2, 0, 1'b1, 8'd2);
        pcyc(2, 1);
        period(2);
        period(2);

        // N=3 then N=255
        pcyc(2, 0); pcyc(2, 1, 1'b1, 8'd3);
        period(3);
        pcyc(3, 0); pcyc(3, 1, 1'b1, 8'd255); pcyc(3, 2);
        period(255);
        for (int k = 0; k < 255; k++) begin
            if (k == 10) pcyc(255, k, 1'b1, 8'd5);
            else         pcyc(255, k);
        end

        // Enable dropped at cnt=1: odd-N extension holds clk_out only until the falling edge
        period(5);
        pcyc(5, 0); pcyc(5, 1);
        idle(1'b0, 1'b1, 8'd5);
        idle(1'b0, 1'b0, 8'd5);
        idle(1'b0, 1'b0, 8'd5);
        period(5);
        period(5);

        // Reset in high phase with pending 7: pend discarded, N=5 resumes
        pcyc(5, 0); pcyc(5, 1, 1'b1, 8'd7);
        begin
            exp_t x;
            x = '{tick: 1'b0, co_rise: 1'b1, co_fall: 1'b0, err: 1'b0, div: 8'd5};
            cyc(1'b1, 1'b1, 1'b0, 8'd0, x);
        end
        period(5);
        period(5);

        check("scoreboard_empty", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
